// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register with load formatting and retire counter
//
// Purpose: captures the MEM-stage instruction on each rising edge, formats load
// data (byte/halfword extraction with sign or zero extension, big-endian lanes),
// drives the register file write port, flags misaligned loads and counts
// retired instructions. Every output is a flop output.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   stall_i, flush_i      either one forces a bubble into WB
//   mem_valid_d           MEM stage holds a real instruction
//   mem_reg_write_d       instruction writes a GPR
//   mem_mem_to_reg_d      1 = load data, 0 = ALU result
//   mem_load_type_d       000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others LW
//   mem_byte_off_d        load address bits [1:0]
//   mem_alu_result_d      ALU result
//   mem_load_data_d       raw aligned word from data memory
//   mem_dest_d            destination register
//   write_q               register file write enable
//   write_addr_q          register file write address
//   write_data_q          register file write data
//   wb_valid_q            valid, non-faulting instruction in WB
//   misalign_q            one-cycle pulse for a load with an illegal offset
//   retire_cnt_q          retired-instruction count (wraps)
module wb_stage #(
  parameter int WIDTH     = 32,
  parameter int R_WIDTH   = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 mem_valid_d,
  input  logic                 mem_reg_write_d,
  input  logic                 mem_mem_to_reg_d,
  input  logic [2:0]           mem_load_type_d,
  input  logic [1:0]           mem_byte_off_d,
  input  logic [WIDTH-1:0]     mem_alu_result_d,
  input  logic [WIDTH-1:0]     mem_load_data_d,
  input  logic [R_WIDTH-1:0]   mem_dest_d,
  output logic                 write_q,
  output logic [R_WIDTH-1:0]   write_addr_q,
  output logic [WIDTH-1:0]     write_data_q,
  output logic                 wb_valid_q,
  output logic                 misalign_q,
  output logic [CNT_WIDTH-1:0] retire_cnt_q
);

  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic             take;
  logic             misalign_c;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_fmt;
  logic [WIDTH-1:0] wdata_c;

  // A bubble is captured whenever the MEM slot is empty, stalled or killed.
  assign take = mem_valid_d & ~stall_i & ~flush_i;

  // Big-endian lanes: offset 0 is the most significant byte of the word.
  always_comb begin
    byte_sel = '0;
    case (mem_byte_off_d)
      2'd0:    byte_sel = mem_load_data_d[WIDTH-1  -: 8];
      2'd1:    byte_sel = mem_load_data_d[WIDTH-9  -: 8];
      2'd2:    byte_sel = mem_load_data_d[WIDTH-17 -: 8];
      default: byte_sel = mem_load_data_d[WIDTH-25 -: 8];
    endcase
  end

  // Only offsets 0 and 2 are legal for halfwords, so bit 1 picks the half.
  assign half_sel = mem_byte_off_d[1] ? mem_load_data_d[WIDTH-17 -: 16]
                                      : mem_load_data_d[WIDTH-1  -: 16];

  always_comb begin
    load_fmt   = mem_load_data_d;
    misalign_c = 1'b0;
    case (mem_load_type_d)
      LT_LH: begin
        load_fmt   = {{(WIDTH-16){half_sel[15]}}, half_sel};
        misalign_c = mem_byte_off_d[0];
      end
      LT_LHU: begin
        load_fmt   = {{(WIDTH-16){1'b0}}, half_sel};
        misalign_c = mem_byte_off_d[0];
      end
      LT_LB: begin
        load_fmt = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      end
      LT_LBU: begin
        load_fmt = {{(WIDTH-8){1'b0}}, byte_sel};
      end
      default: begin
        // LW and the unused encodings: whole word, offset 0 only.
        load_fmt   = mem_load_data_d;
        misalign_c = (mem_byte_off_d != 2'd0);
      end
    endcase
    // ALU results never fault, regardless of stale load_type/byte_off.
    if (!mem_mem_to_reg_d) begin
      misalign_c = 1'b0;
    end
  end

  assign wdata_c = mem_mem_to_reg_d ? load_fmt : mem_alu_result_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q      <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      wb_valid_q   <= 1'b0;
      misalign_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else if (!take) begin
      write_q      <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      wb_valid_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      // r0 is hardwired to zero, so a write to it is never requested.
      write_q      <= mem_reg_write_d & (mem_dest_d != '0) & ~misalign_c;
      write_addr_q <= mem_dest_d;
      write_data_q <= wdata_c;
      wb_valid_q   <= ~misalign_c;
      misalign_q   <= misalign_c;
      if (!misalign_c) begin
        retire_cnt_q <= retire_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized self-checking bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        reg_write = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic [2:0]  load_type = 3'd0;
  logic [1:0]  byte_off = 2'd0;
  logic [31:0] alu = '0;
  logic [31:0] ldata = '0;
  logic [4:0]  dest = '0;

  logic        write_q, wb_valid_q, misalign_q;
  logic [4:0]  write_addr_q;
  logic [31:0] write_data_q;
  logic [31:0] retire_cnt_q;

  logic        w4_write, w4_valid, w4_mis;
  logic [4:0]  w4_addr;
  logic [31:0] w4_data;
  logic [3:0]  w4_cnt;

  int checks = 0;
  int errors = 0;
  int unsigned mcnt = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .mem_valid_d(valid), .mem_reg_write_d(reg_write), .mem_mem_to_reg_d(mem_to_reg),
    .mem_load_type_d(load_type), .mem_byte_off_d(byte_off),
    .mem_alu_result_d(alu), .mem_load_data_d(ldata), .mem_dest_d(dest),
    .write_q(write_q), .write_addr_q(write_addr_q), .write_data_q(write_data_q),
    .wb_valid_q(wb_valid_q), .misalign_q(misalign_q), .retire_cnt_q(retire_cnt_q)
  );

  wb_stage #(.CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .mem_valid_d(valid), .mem_reg_write_d(reg_write), .mem_mem_to_reg_d(mem_to_reg),
    .mem_load_type_d(load_type), .mem_byte_off_d(byte_off),
    .mem_alu_result_d(alu), .mem_load_data_d(ldata), .mem_dest_d(dest),
    .write_q(w4_write), .write_addr_q(w4_addr), .write_data_q(w4_data),
    .wb_valid_q(w4_valid), .misalign_q(w4_mis), .retire_cnt_q(w4_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input bit [2:0] lt, input bit [1:0] off);
    if (lt == 3'd3 || lt == 3'd4) return 1'b1;
    if (lt == 3'd1 || lt == 3'd2) return (off == 0 || off == 2);
    return (off == 0);
  endfunction

  // Reference formatting from plain shifts and two's-complement arithmetic.
  function automatic bit [31:0] ref_data(input bit m2r, input bit [2:0] lt, input bit [1:0] off,
                                         input bit [31:0] a, input bit [31:0] w);
    int unsigned v;
    if (!m2r) return a;
    case (lt)
      3'd1, 3'd2: begin
        v = (w >> ((2 - int'(off)) * 8)) % 65536;
        if (lt == 3'd1 && v >= 32768) return 32'(v) - 32'd65536;
        return 32'(v);
      end
      3'd3, 3'd4: begin
        v = (w >> ((3 - int'(off)) * 8)) % 256;
        if (lt == 3'd3 && v >= 128) return 32'(v) - 32'd256;
        return 32'(v);
      end
      default: return w;
    endcase
  endfunction

  task automatic step(input string tag, input bit v, input bit rw, input bit m2r,
                      input bit [2:0] lt, input bit [1:0] off, input bit [31:0] a,
                      input bit [31:0] w, input bit [4:0] d, input bit st, input bit fl);
    bit take, mis, we;
    bit [31:0] ed;
    valid = v; reg_write = rw; mem_to_reg = m2r; load_type = lt; byte_off = off;
    alu = a; ldata = w; dest = d; stall = st; flush = fl;
    take = v && !st && !fl;
    mis  = take && m2r && !legal(lt, off);
    we   = take && !mis && rw && (d != 0);
    ed   = ref_data(m2r, lt, off, a, w);
    if (take && !mis) mcnt++;
    @(posedge clk); #1;
    check({tag, "_we"}, 64'(write_q), 64'(we));
    check({tag, "_valid"}, 64'(wb_valid_q), 64'(take && !mis));
    check({tag, "_mis"}, 64'(misalign_q), 64'(mis));
    check({tag, "_cnt"}, 64'(retire_cnt_q), 64'(mcnt));
    check({tag, "_cnt4"}, 64'(w4_cnt), 64'(mcnt % 16));
    check({tag, "_we4"}, 64'({w4_write, w4_valid, w4_mis}), 64'({we, take && !mis, mis}));
    if (!take) begin
      check({tag, "_addr0"}, 64'(write_addr_q), 64'(0));
      check({tag, "_data0"}, 64'(write_data_q), 64'(0));
    end else if (!mis) begin
      check({tag, "_addr"}, 64'(write_addr_q), 64'(d));
      check({tag, "_data"}, 64'(write_data_q), 64'(ed));
      check({tag, "_data4"}, 64'({w4_addr, w4_data}), 64'({d, ed}));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_zero"}, 64'({write_q, write_addr_q, write_data_q, wb_valid_q, misalign_q}), 64'(0));
    check({tag, "_cntz"}, 64'(retire_cnt_q), 64'(0));
    check({tag, "_cnt4z"}, 64'(w4_cnt), 64'(0));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_zero("rst");
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam bit [31:0] LW_WORD = 32'h80FF_7F01;

  initial begin
    #1 check_zero("por");
    @(negedge clk);
    rst = 1'b0;

    step("alu", 1, 1, 0, 3'd5, 2'd3, 32'h1234_5678, 32'hDEAD_BEEF, 5'd8, 0, 0);
    check("alu_lit", 64'({write_q, write_addr_q, write_data_q, retire_cnt_q}),
          64'({1'b1, 5'd8, 32'h1234_5678}) << 32 | 64'd1);

    step("lb0",  1, 1, 1, 3'd3, 2'd0, 0, LW_WORD, 5'd3, 0, 0);
    check("lb0_lit", 64'(write_data_q), 64'(32'hFFFF_FF80));
    step("lbu0", 1, 1, 1, 3'd4, 2'd0, 0, LW_WORD, 5'd3, 0, 0);
    check("lbu0_lit", 64'(write_data_q), 64'(32'h0000_0080));
    step("lb2",  1, 1, 1, 3'd3, 2'd2, 0, LW_WORD, 5'd3, 0, 0);
    check("lb2_lit", 64'(write_data_q), 64'(32'h0000_007F));
    step("lh0",  1, 1, 1, 3'd1, 2'd0, 0, LW_WORD, 5'd3, 0, 0);
    check("lh0_lit", 64'(write_data_q), 64'(32'hFFFF_80FF));
    step("lhu2", 1, 1, 1, 3'd2, 2'd2, 0, LW_WORD, 5'd3, 0, 0);
    check("lhu2_lit", 64'(write_data_q), 64'(32'h0000_7F01));
    step("lw0",  1, 1, 1, 3'd0, 2'd0, 0, LW_WORD, 5'd3, 0, 0);
    check("lw0_lit", 64'(write_data_q), 64'(32'h80FF_7F01));

    step("lh1",  1, 1, 1, 3'd1, 2'd1, 0, LW_WORD, 5'd5, 0, 0);
    check("lh1_lit", 64'({misalign_q, write_q, wb_valid_q, retire_cnt_q}), 64'({3'b100, 32'd7}));
    step("lw2",  1, 1, 1, 3'd0, 2'd2, 0, LW_WORD, 5'd5, 0, 0);
    step("after", 1, 1, 0, 3'd0, 2'd0, 32'h5, 0, 5'd6, 0, 0);

    step("r0",   1, 1, 0, 3'd0, 2'd0, 32'h77, 0, 5'd0, 0, 0);
    step("stl1", 1, 1, 0, 3'd0, 2'd0, 32'h1, 0, 5'd9, 1, 0);
    step("stl2", 1, 1, 0, 3'd0, 2'd0, 32'h2, 0, 5'd9, 1, 0);
    step("fls",  1, 1, 0, 3'd0, 2'd0, 32'h3, 0, 5'd9, 0, 1);
    step("both", 1, 1, 0, 3'd0, 2'd0, 32'h4, 0, 5'd9, 1, 1);
    step("inv",  0, 1, 0, 3'd0, 2'd0, 32'h5, 0, 5'd9, 0, 0);

    for (int i = 0; i < 3; i++) step("pre", 1, 1, 0, 3'd0, 2'd0, $urandom, 0, 5'd4, 0, 0);
    do_reset();
    check_zero("rel");
    step("post", 1, 1, 0, 3'd0, 2'd0, 32'hA5, 0, 5'd2, 0, 0);
    check("post_lit", 64'(retire_cnt_q), 64'd1);

    do_reset();
    for (int i = 0; i < 15; i++) step("wrap", 1, 0, 0, 3'd0, 2'd0, $urandom, 0, 5'($urandom), 0, 0);
    check("wrap15", 64'(w4_cnt), 64'd15);
    step("wrap", 1, 1, 1, 3'd3, 2'd1, 0, $urandom, 5'd1, 0, 0);
    check("wrap0", 64'(w4_cnt), 64'd0);
    check("nowrap16", 64'(retire_cnt_q), 64'd16);

    for (int i = 0; i < 400; i++) begin
      step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           3'($urandom_range(0, 7)), 2'($urandom), $urandom, $urandom,
           5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
